onehotclk_multi_enable: RTL and testbench



---
 rtl/onehotclk_pkg.sv | 25 ++
 rtl/onehotclk_sync2.sv | 25 ++
 rtl/onehotclk_multi_enable.sv | 146 ++++++++++++++
 tb/tb_onehotclk_multi_enable.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/onehotclk_pkg.sv
// Shared definitions for the one-hot clock-gate enable controller.
//   ohc_state_e : controller mode encoding
//   *_MIN/*_MAX : legal ranges for NUM_CH and SETTLE_CYC
//   CNT_W       : width of the settle counter (holds up to SETTLE_MAX-1)
//   sel_width() : channel-select width, never narrower than one bit
package onehotclk_pkg;

    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 16;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_FUNC   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_TEST   = 2'd2,
        ST_RESUME = 2'd3
    } ohc_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehotclk_sync2.sv
// Two-flop synchronizer for the asynchronous test-mode request.
//   nvdla_core_clk  : destination clock
//   nvdla_core_rstn : asynchronous active-low reset, both stages clear to 0
//   d               : asynchronous input
//   q               : synchronized output (second stage)
module onehotclk_sync2 (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rstn,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/onehotclk_multi_enable.sv
// Clock-gate enable controller with a one-hot DFT test mode.
// In functional mode the gates follow func_en; in test mode only the channel
// selected by the one-hot token may be enabled. Every mode change passes
// through an all-off window of SETTLE_CYC cycles.
//   nvdla_core_clk  : clock
//   nvdla_core_rstn : asynchronous active-low reset
//   one_hot_enable  : test-mode request (asynchronous)
//   tp_advance      : rotate token left by one (TEST only)
//   tp_sel_load     : load token from tp_sel (TEST only)
//   tp_sel          : channel index for tp_sel_load
//   func_en         : per-channel functional enables
//   enable_out      : registered clock-gate enables
//   token           : current one-hot test token
//   mode_busy       : high while draining or resuming
//   sel_err         : sticky, set by an out-of-range tp_sel_load
//
// state     | meaning
// ST_FUNC   | functional mode, enable_out follows func_en
// ST_DRAIN  | all gates off, counting down before entering test mode
// ST_TEST   | test mode, enable_out = token & func_en
// ST_RESUME | all gates off, counting down before returning to functional
module onehotclk_multi_enable
    import onehotclk_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int SETTLE_CYC = 4,
    localparam int SEL_W      = sel_width(NUM_CH)
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              one_hot_enable,
    input  logic              tp_advance,
    input  logic              tp_sel_load,
    input  logic [SEL_W-1:0]  tp_sel,
    input  logic [NUM_CH-1:0] func_en,
    output logic [NUM_CH-1:0] enable_out,
    output logic [NUM_CH-1:0] token,
    output logic              mode_busy,
    output logic              sel_err
);

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]    NUM_CH_W    = (SEL_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] TOKEN_BIT0  = NUM_CH'(1);

    logic              ohe_s;
    ohc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] token_q, token_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic              sel_err_q, sel_err_d;
    logic              sel_oor;

    onehotclk_sync2 u_sync (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .d               (one_hot_enable),
        .q               (ohe_s)
    );

    // Widened by one bit so the compare holds even when NUM_CH is a power of two.
    assign sel_oor = ({1'b0, tp_sel} >= NUM_CH_W);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        token_d   = token_q;
        en_d      = '0;
        sel_err_d = sel_err_q | (tp_sel_load & sel_oor);

        case (state_q)
            ST_FUNC: begin
                en_d = func_en;
                if (ohe_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = SETTLE_LOAD;
                    token_d = TOKEN_BIT0;
                end
            end
            ST_DRAIN: begin
                // A withdrawn request aborts the drain before it can reach TEST.
                if (!ohe_s) begin
                    state_d = ST_RESUME;
                    cnt_d   = SETTLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_TEST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TEST: begin
                en_d = token_q & func_en;
                // A load, even a rejected one, swallows a same-cycle advance.
                if (tp_sel_load) begin
                    if (!sel_oor) begin
                        token_d = TOKEN_BIT0 << tp_sel;
                    end
                end else if (tp_advance) begin
                    token_d = {token_q[NUM_CH-2:0], token_q[NUM_CH-1]};
                end
                if (!ohe_s) begin
                    state_d = ST_RESUME;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_RESUME: begin
                if (ohe_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = SETTLE_LOAD;
                    token_d = TOKEN_BIT0;
                end else if (cnt_q == '0) begin
                    state_d = ST_FUNC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_FUNC;
                cnt_d   = '0;
                token_d = TOKEN_BIT0;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= ST_FUNC;
            cnt_q     <= '0;
            token_q   <= TOKEN_BIT0;
            en_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            token_q   <= token_d;
            en_q      <= en_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign enable_out = en_q;
    assign token      = token_q;
    assign mode_busy  = (state_q == ST_DRAIN) || (state_q == ST_RESUME);
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_onehotclk_multi_enable.sv
module tb_onehotclk_multi_enable;

    localparam int NCH = 4;
    localparam int S   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ohe, adv, ld;
    logic [1:0] sel;
    logic [3:0] fe, en, tok;
    logic       busy, err;

    logic       adv3, ld3;
    logic [1:0] sel3;
    logic [2:0] fe3, en3, tok3;
    logic       busy3, err3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: target mode plus cycles elapsed since it last changed.
    bit         m_s1, m_s2, m_tgt, m_err;
    int         m_age;
    logic [3:0] m_en, m_tok;

    always #5 clk = ~clk;

    onehotclk_multi_enable #(.NUM_CH(4), .SETTLE_CYC(S)) dut (
        .nvdla_core_clk (clk), .nvdla_core_rstn (rst_n),
        .one_hot_enable (ohe), .tp_advance (adv), .tp_sel_load (ld),
        .tp_sel (sel), .func_en (fe), .enable_out (en), .token (tok),
        .mode_busy (busy), .sel_err (err)
    );

    onehotclk_multi_enable #(.NUM_CH(3), .SETTLE_CYC(S)) dut3 (
        .nvdla_core_clk (clk), .nvdla_core_rstn (rst_n),
        .one_hot_enable (ohe), .tp_advance (adv3), .tp_sel_load (ld3),
        .tp_sel (sel3), .func_en (fe3), .enable_out (en3), .token (tok3),
        .mode_busy (busy3), .sel_err (err3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_tgt = 0; m_age = S;
        m_en = '0; m_tok = 4'b0001; m_err = 0;
    endtask

    task automatic step(input logic [3:0] f, input bit o, input bit a, input bit l,
                        input logic [1:0] s);
        bit         settled;
        logic [3:0] n_en, n_tok;
        @(negedge clk);
        fe = f; ohe = o; adv = a; ld = l; sel = s;
        settled = (m_age >= S);
        n_tok   = m_tok;
        if (!settled)  n_en = '0;
        else if (m_tgt) n_en = m_tok & f;
        else           n_en = f;
        if (settled && m_tgt) begin
            if (l) begin
                if (int'(s) < NCH) n_tok = 4'(1 << s);
            end else if (a) begin
                n_tok = (m_tok == 4'b1000) ? 4'b0001 : 4'(m_tok * 2);
            end
        end
        if (l && int'(s) >= NCH) m_err = 1;
        if (m_s2 != m_tgt) begin
            m_tgt = m_s2;
            m_age = 0;
            if (m_s2) n_tok = 4'b0001;
        end else if (m_age < S) begin
            m_age++;
        end
        m_s2 = m_s1; m_s1 = o;
        m_en = n_en; m_tok = n_tok;
        @(posedge clk); #1;
        chk("enable_out", en, m_en);
        chk("token", tok, m_tok);
        chk("mode_busy", busy, (m_age < S));
        chk("sel_err", err, m_err);
        chk("token_onehot", $onehot(tok), 1);
    endtask

    initial begin
        logic [3:0] exp_tok [4];
        int zero_cnt, busy_cnt;
        bit o_r;
        exp_tok = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 0; ohe = 0; adv = 0; ld = 0; sel = 0; fe = 0;
        adv3 = 0; ld3 = 0; sel3 = 0; fe3 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_enable_out", en, 4'b0000);
        chk("rst_token", tok, 4'b0001);
        chk("rst_busy", busy, 0);
        chk("rst_sel_err", err, 0);
        rst_n = 1;

        // First edge after reset release already forwards func_en.
        step(4'b1011, 0, 0, 0, 0);
        chk("first_edge_en", en, 4'b1011);

        // Enter test mode: four all-off cycles, then channel 0 only.
        zero_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'hF, 1, 0, 0, 0);
            if (en == 4'b0000) zero_cnt++;
            if (busy) busy_cnt++;
        end
        chk("drain_zero_cycles", zero_cnt, 4);
        chk("drain_busy_cycles", busy_cnt, 4);
        chk("test_first_en", en, 4'b0001);

        for (int k = 0; k < 4; k++) begin
            step(4'hF, 1, 1, 0, 0);
            chk("advance_token", tok, exp_tok[k]);
        end

        // Load wins over advance; out-of-range load on the 3-channel instance.
        ld3 = 1; sel3 = 2'd3;
        step(4'hF, 1, 1, 1, 2'd2);
        chk("load_over_adv", tok, 4'b0100);
        chk("oor_token3", tok3, 3'b001);
        chk("oor_sel_err3", err3, 1);
        sel3 = 2'd2;
        step(4'hF, 1, 0, 0, 0);
        chk("load_token3", tok3, 3'b100);
        chk("sticky_sel_err3", err3, 1);
        ld3 = 0;

        // Async reset in TEST with token at the top channel.
        step(4'hF, 1, 1, 0, 0);
        chk("pre_rst_token", tok, 4'b1000);
        @(negedge clk);
        rst_n = 0; ohe = 0; adv = 0; ld = 0;
        #1;
        chk("async_rst_en", en, 4'b0000);
        chk("async_rst_token", tok, 4'b0001);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_sel_err3", err3, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Abort two cycles into the drain.
        zero_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'hF, (i < 2), 0, 0, 0);
            if (en == 4'b0000) zero_cnt++;
            if (busy) busy_cnt++;
        end
        chk("abort_zero_cycles", zero_cnt, 6);
        chk("abort_busy_cycles", busy_cnt, 6);
        chk("abort_resume_en", en, 4'hF);

        // Randomized traffic against the model.
        o_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) o_r = ~o_r;
            step(4'($urandom_range(0, 15)), o_r, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
